// File: rtl/led_scan_ctrl_if.sv
// Scan controller <-> RX datapath / panel signal bundle.
// master: the scan controller; slave: the datapath/panel side.
interface led_scan_ctrl_if #(
  parameter int ROW_BITS = 4,
  parameter int PWM_BITS = 6
);
  logic                enable;
  logic                pix_strobe;
  logic                shift_en;
  logic [PWM_BITS-1:0] pwm_value;
  logic [ROW_BITS-1:0] row_addr;
  logic                led_lat;
  logic                led_oe_n;
  logic                fifo_rrst_n;
  logic                frame_done;

  modport master (
    input  enable,
    input  pix_strobe,
    output shift_en,
    output pwm_value,
    output row_addr,
    output led_lat,
    output led_oe_n,
    output fifo_rrst_n,
    output frame_done
  );

  modport slave (
    output enable,
    output pix_strobe,
    input  shift_en,
    input  pwm_value,
    input  row_addr,
    input  led_lat,
    input  led_oe_n,
    input  fifo_rrst_n,
    input  frame_done
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// LED panel row scan controller (shift / blank / latch per row).
// Define LED_SCAN_GHOST_BLANK_EN for a BLANK_CYC-long blank phase.
module led_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ROW_BITS  = 4,
  parameter int PWM_BITS  = 6,
  parameter int BLANK_CYC = 4
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  led_scan_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RRST,
    SHIFT,
    BLANK,
    LATCH
  } state_e;

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
  localparam logic [ROW_BITS-1:0] RowLast = '1;

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ROW_BITS-1:0] srow_q, srow_d;
  logic                first_q, first_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [ROW_BITS-1:0] raddr_q, raddr_d;
  logic                shen_q, shen_d;
  logic                lat_q, lat_d;
  logic                oen_q, oen_d;
  logic                rrstn_q, rrstn_d;
  logic                fdone_q, fdone_d;
  logic                frame_end;
  logic                blank_last;

`ifdef LED_SCAN_GHOST_BLANK_EN
  localparam logic [3:0] BlankLast = 4'(BLANK_CYC - 1);
  logic [3:0] bcnt_q, bcnt_d;
  assign blank_last = (bcnt_q == BlankLast);
`else
  assign blank_last = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    srow_d    = srow_q;
    first_d   = first_q;
    pwm_d     = pwm_q;
    raddr_d   = raddr_q;
    frame_end = 1'b0;
`ifdef LED_SCAN_GHOST_BLANK_EN
    bcnt_d    = bcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = RRST;
          col_d   = '0;
          srow_d  = '0;
          pwm_d   = '0;
          first_d = 1'b1;
        end
      end
      RRST: state_d = SHIFT;
      SHIFT: begin
        if (bus.pix_strobe) begin
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = BLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      BLANK: begin
        if (blank_last) begin
          raddr_d = srow_q;
          state_d = LATCH;
        end
`ifdef LED_SCAN_GHOST_BLANK_EN
        bcnt_d = blank_last ? 4'd0 : bcnt_q + 4'd1;
`endif
      end
      LATCH: begin
        first_d = 1'b0;
        state_d = bus.enable ? SHIFT : IDLE;
        if (srow_q == RowLast) begin
          srow_d    = '0;
          pwm_d     = pwm_q + 1'b1;
          frame_end = 1'b1;
        end else begin
          srow_d = srow_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered images of the state being entered
    shen_d  = (state_d == SHIFT);
    lat_d   = (state_d == LATCH);
    oen_d   = !((state_d == SHIFT) && !first_d);
    rrstn_d = !((state_d == RRST) || frame_end);
    fdone_d = frame_end;
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q <= IDLE;
      col_q   <= '0;
      srow_q  <= '0;
      first_q <= 1'b1;
      pwm_q   <= '0;
      raddr_q <= '0;
      shen_q  <= 1'b0;
      lat_q   <= 1'b0;
      oen_q   <= 1'b1;
      rrstn_q <= 1'b1;
      fdone_q <= 1'b0;
`ifdef LED_SCAN_GHOST_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      srow_q  <= srow_d;
      first_q <= first_d;
      pwm_q   <= pwm_d;
      raddr_q <= raddr_d;
      shen_q  <= shen_d;
      lat_q   <= lat_d;
      oen_q   <= oen_d;
      rrstn_q <= rrstn_d;
      fdone_q <= fdone_d;
`ifdef LED_SCAN_GHOST_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.shift_en    = shen_q;
  assign bus.pwm_value   = pwm_q;
  assign bus.row_addr    = raddr_q;
  assign bus.led_lat     = lat_q;
  assign bus.led_oe_n    = oen_q;
  assign bus.fifo_rrst_n = rrstn_q;
  assign bus.frame_done  = fdone_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl (COLS=4, 2 rows, 2-bit PWM).
// Blank length expectation follows LED_SCAN_GHOST_BLANK_EN.
module tb_led_scan_ctrl;

`ifdef LED_SCAN_GHOST_BLANK_EN
  localparam int BLK = 3;
`else
  localparam int BLK = 1;
`endif

  logic clk;
  logic in_nrst;
  int   n_chk;
  int   n_fail;
  int   mode;

  led_scan_ctrl_if #(.ROW_BITS(1), .PWM_BITS(2)) bus ();

  led_scan_ctrl #(
    .COLS(4),
    .ROW_BITS(1),
    .PWM_BITS(2),
    .BLANK_CYC(3)
  ) dut (
    .in_clk (clk),
    .in_nrst(in_nrst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobe generator: 0 = off, 1 = every 2nd cycle, 2 = held high
  initial begin
    bus.pix_strobe = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        1: bus.pix_strobe = ~bus.pix_strobe;
        2: bus.pix_strobe = 1'b1;
        default: bus.pix_strobe = 1'b0;
      endcase
    end
  end

  int n_acc, sh_cyc, rbase, sbase, row_strb, row_sh;
  int gap, last_gap, n_fd, n_rrst;
  bit gap_open;
  int fd_pwm[16];
  int fd_rrst[16];

  initial begin
    n_acc = 0; sh_cyc = 0; rbase = 0; sbase = 0;
    row_strb = 0; row_sh = 0; gap = 0; last_gap = 0;
    n_fd = 0; n_rrst = 0; gap_open = 0;
    forever begin
      @(negedge clk);
      if (bus.shift_en && bus.pix_strobe) n_acc++;
      if (bus.shift_en) begin
        sh_cyc++;
        if (gap_open) begin
          last_gap = gap;
          gap_open = 0;
        end
      end else begin
        if (!gap_open) begin
          gap_open = 1;
          gap = 0;
        end
        gap = bus.led_oe_n ? gap + 1 : 100;
      end
      if (bus.led_lat) begin
        row_strb = n_acc - rbase;
        row_sh   = sh_cyc - sbase;
        rbase    = n_acc;
        sbase    = sh_cyc;
      end
      if (!bus.fifo_rrst_n && !bus.shift_en && !bus.frame_done) begin
        rbase = n_acc;
        sbase = sh_cyc;
      end
      if (bus.frame_done) begin
        fd_pwm[n_fd % 16]  = int'(bus.pwm_value);
        fd_rrst[n_fd % 16] = int'(bus.fifo_rrst_n);
        n_fd++;
      end
      if (!bus.fifo_rrst_n) n_rrst++;
    end
  end

  task automatic wait_lat(input int want_row, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.led_lat && (want_row < 0 || int'(bus.row_addr) == want_row)) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check(tag, 0, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_acc >= target) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check(tag, 0, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    check({pfx, "_shift_en"}, bus.shift_en, 0);
    check({pfx, "_pwm"}, bus.pwm_value, 0);
    check({pfx, "_row"}, bus.row_addr, 0);
    check({pfx, "_lat"}, bus.led_lat, 0);
    check({pfx, "_oe_n"}, bus.led_oe_n, 1);
    check({pfx, "_rrst_n"}, bus.fifo_rrst_n, 1);
    check({pfx, "_fdone"}, bus.frame_done, 0);
  endtask

  int fd0, rr0, a0;

  initial begin
    n_chk = 0;
    n_fail = 0;
    mode = 0;
    in_nrst = 1'b0;
    bus.enable = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    in_nrst = 1'b1;
    tick();
    tick();
    check("idle_shift_en", bus.shift_en, 0);
    check("idle_oe_n", bus.led_oe_n, 1);

    bus.enable = 1'b1;
    tick();
    check("rrst_low", bus.fifo_rrst_n, 0);
    check("rrst_shift_en", bus.shift_en, 0);
    check("rrst_pwm", bus.pwm_value, 0);
    tick();
    check("rrst_one_cycle", bus.fifo_rrst_n, 1);
    check("row0_shift_en", bus.shift_en, 1);
    check("row0_oe_n", bus.led_oe_n, 1);
    mode = 1;
    wait_lat(-1, "row0_lat_timeout");
    check("row0_lat_row", bus.row_addr, 0);
    check("row0_strobes", row_strb, 4);

    fd0 = n_fd;
    rr0 = n_rrst;
    for (int i = 0; i < 2000 && n_fd < fd0 + 4; i++) tick();
    check("frames_done", n_fd - fd0, 4);
    check("fd_pwm1", fd_pwm[(fd0 + 0) % 16], 1);
    check("fd_pwm2", fd_pwm[(fd0 + 1) % 16], 2);
    check("fd_pwm3", fd_pwm[(fd0 + 2) % 16], 3);
    check("fd_pwm0", fd_pwm[(fd0 + 3) % 16], 0);
    for (int i = 0; i < 4; i++)
      check("fd_rrst_low", fd_rrst[(fd0 + i) % 16], 0);
    check("rrst_pulses", n_rrst - rr0, 4);
    check("gap_len", last_gap, BLK + 1);
    check("run_shift_en", bus.shift_en, 1);
    check("run_oe_n", bus.led_oe_n, 0);

    wait_lat(0, "pre_drop_timeout");
    a0 = n_acc;
    wait_acc(a0 + 2, "drop_acc_timeout");
    bus.enable = 1'b0;
    wait_lat(-1, "drop_lat_timeout");
    check("drop_lat_row", bus.row_addr, 1);
    check("drop_strobes", n_acc - a0, 4);
    a0 = n_acc;
    tick();
    check("drop_fdone", bus.frame_done, 1);
    check("drop_pwm", bus.pwm_value, 1);
    tick();
    tick();
    tick();
    check("idle2_shift_en", bus.shift_en, 0);
    check("idle2_oe_n", bus.led_oe_n, 1);
    check("idle2_no_acc", n_acc - a0, 0);
    bus.enable = 1'b1;
    tick();
    check("reen_rrst", bus.fifo_rrst_n, 0);
    check("reen_pwm", bus.pwm_value, 0);
    mode = 2;
    tick();
    check("reen_shift_en", bus.shift_en, 1);

    wait_lat(-1, "hold_lat0_timeout");
    check("hold_r0_strobes", row_strb, 4);
    check("hold_r0_cycles", row_sh, 4);
    wait_lat(-1, "hold_lat1_timeout");
    check("hold_r1_row", bus.row_addr, 1);
    check("hold_r1_strobes", row_strb, 4);
    check("hold_r1_cycles", row_sh, 4);
    check("hold_gap", last_gap, BLK + 1);

    tick();
    a0 = n_acc;
    wait_acc(a0 + 2, "arst_acc_timeout");
    check("arst_pre_shift", bus.shift_en, 1);
    check("arst_pre_row", bus.row_addr, 1);
    check("arst_pre_pwm", bus.pwm_value, 1);
    #2;
    in_nrst = 1'b0;
    #1;
    chk_reset_vals("arst");
    mode = 0;
    #20;
    in_nrst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- COLS, 64, pixels shifted per row.
- ROW_BITS, 4, row address width; rows = 2^ROW_BITS.
- PWM_BITS, 6, PWM compare value width.
- BLANK_CYC, 4, blanking length in cycles when ghost blanking is compiled in; legal range 1..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- in_clk, input, 1, single clock; all logic on its rising edge.
- in_nrst, input, 1, asynchronous active-low reset.
- enable, input, 1, scan run request.
- pix_strobe, input, 1, one-cycle pulse per pixel delivered by the RX datapath.
- shift_en, output, 1, gates the LED shift clock and pixel reads; high only in SHIFT.
- pwm_value, output, PWM_BITS, compare value driven to the RX datapath.
- row_addr, output, ROW_BITS, panel row address (the displayed row).
- led_lat, output, 1, panel latch pulse.
- led_oe_n, output, 1, panel output enable, active-low.
- fifo_rrst_n, output, 1, AL422 read-pointer reset, active-low.
- frame_done, output, 1, one-cycle pulse at the end of each full frame pass.
REQ-003 All outputs SHALL be registered.

Function
REQ-010 The FSM SHALL have the states IDLE, RRST, SHIFT, BLANK and LATCH.
REQ-011 IDLE: shift_en=0 and led_oe_n=1; when enable=1 the FSM SHALL go to RRST.
REQ-012 RRST: lasts 1 cycle; fifo_rrst_n=0, shift_row=0, pwm_value=0; the FSM then goes to SHIFT.
REQ-013 SHIFT: shift_en=1; col_cnt SHALL increment on each pix_strobe; pix_strobe with col_cnt==COLS-1 SHALL clear col_cnt and go to BLANK.
REQ-014 During SHIFT, led_oe_n SHALL be 0, displaying the previously latched row, except during the first row after RRST, when led_oe_n SHALL be 1.
REQ-015 BLANK: led_oe_n=1 and shift_en=0; lasts BLANK_CYC cycles (REQ-040/041); on exit row_addr SHALL take shift_row, then the FSM goes to LATCH.
REQ-016 LATCH: led_lat=1 for exactly 1 cycle and led_oe_n=1.
REQ-017 On LATCH exit with shift_row<rows-1: shift_row SHALL increment; the FSM goes to SHIFT if enable=1, else IDLE.
REQ-018 On LATCH exit with shift_row==rows-1: shift_row SHALL become 0, pwm_value SHALL increment (2^PWM_BITS-1 wraps to 0), frame_done SHALL pulse 1 cycle, and fifo_rrst_n SHALL pulse low 1 cycle (the same cycle); the FSM then goes to SHIFT, or IDLE if enable=0.
REQ-019 If enable falls mid-row, the current row SHALL complete through LATCH before entering IDLE; re-enable SHALL always restart via RRST at row 0, pwm 0.
REQ-020 pix_strobe outside SHIFT SHALL be ignored.
REQ-021 row_addr SHALL change only on BLANK exit, while led_oe_n=1.

Reset
REQ-030 While in_nrst=0: state=IDLE, shift_en=0, pwm_value=0, row_addr=0, led_lat=0, led_oe_n=1, fifo_rrst_n=1, frame_done=0, and col_cnt, shift_row and the blank counter = 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately to the REQ-030 values, with no completion of the current row.

Configuration
REQ-040 With LED_SCAN_GHOST_BLANK_EN defined: BLANK SHALL last BLANK_CYC cycles, counted by a 4-bit counter.
REQ-041 Without LED_SCAN_GHOST_BLANK_EN: BLANK SHALL last exactly 1 cycle, the BLANK_CYC parameter SHALL be ignored, and no blank counter SHALL be built.

Verification (COLS=4, ROW_BITS=1, PWM_BITS=2, BLANK_CYC=3, pix_strobe every 2nd cycle)
REQ-050 Reset, then enable=1 -> fifo_rrst_n low for 1 cycle, then shift_en=1; row 0 uses led_oe_n=1; after 4 strobes, BLANK then LATCH, with row_addr=0 and one led_lat pulse.
REQ-051 Run 4 frames -> frame_done pulses 4 times, pwm_value sequence 0,1,2,3,0, and each frame_done coincides with a 1-cycle fifo_rrst_n low.
REQ-052 Macro defined -> led_oe_n=1 for exactly 3 BLANK cycles plus 1 LATCH cycle per row; macro undefined -> 1 plus 1.
REQ-053 Drop enable after the 2nd strobe of row 1 -> 2 more strobes accepted, BLANK and LATCH executed, row_addr=1, then IDLE with led_oe_n=1; re-enable -> RRST, with pwm_value=0.
REQ-054 Assert in_nrst in SHIFT at col_cnt=2 -> all outputs at REQ-030 values in the same cycle, asynchronously.
REQ-055 pix_strobe held high during BLANK and LATCH -> col_cnt unchanged and the next row still takes exactly 4 strobes.
